// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding RV32I byte/half/word access to a word-addressed memory.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning them down.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wd,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] merged_q, merged_d;

    logic        bad_funct3, out_of_range, misaligned, reject;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext, merged_word;

    always_comb begin
        bad_funct3   = is_store ? (funct3 > 3'd2)
                                : (funct3 == 3'd3 || funct3 >= 3'd6);
        out_of_range = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned   = (funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        misaligned   = 1'b0;
`endif
        reject       = bad_funct3 || out_of_range || misaligned;
    end

    // Unused low address bits naturally align the access down when not trapping.
    always_comb begin
        rd_byte     = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        rd_half     = mem_rd[{addr_q[1], 4'b0000} +: 16];
        merged_word = mem_rd;
        if (funct3_q[1:0] == 2'b00)
            merged_word[{addr_q[1:0], 3'b000} +: 8] = store_data_q[7:0];
        else
            merged_word[{addr_q[1], 4'b0000} +: 16] = store_data_q[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'b0, rd_byte};
            3'd5:    load_ext = {16'b0, rd_half};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        err_d        = err_q;
        load_data_d  = load_data_q;
        merged_d     = merged_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d   = is_store;
                    funct3_d     = funct3;
                    addr_d       = addr;
                    store_data_d = store_data;
                    err_d        = reject;
                    load_data_d  = 32'b0;
                    merged_d     = 32'b0;
                    if (reject)                 state_d = RESP;
                    else if (!is_store)         state_d = LOAD;
                    else if (funct3 == 3'd2)    state_d = WRITE;
                    else                        state_d = RMW_RD;
                end
            end
            LOAD: begin
                load_data_d = load_ext;
                state_d     = RESP;
            end
            RMW_RD: begin
                merged_d = merged_word;
                state_d  = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b0;
            addr_q       <= 32'b0;
            store_data_q <= 32'b0;
            err_q        <= 1'b0;
            load_data_q  <= 32'b0;
            merged_q     <= 32'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            err_q        <= err_d;
            load_data_q  <= load_data_d;
            merged_q     <= merged_d;
        end
    end

    always_comb begin
        req_ready    = (state_q == IDLE);
        resp_valid   = (state_q == RESP);
        err          = (state_q == RESP) && err_q;
        load_data    = load_data_q;
        mem_memread  = (state_q == LOAD) || (state_q == RMW_RD);
        mem_memwrite = (state_q == WRITE);
        mem_address  = (state_q == LOAD || state_q == RMW_RD || state_q == WRITE)
                       ? {2'b00, addr_q[31:2]} : 32'b0;
        mem_wd       = (state_q == WRITE) ? (funct3_q == 3'd2 ? store_data_q : merged_q)
                                          : 32'b0;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the downstream data memory.
REQ-002 SHALL have ports: clk input 1, rising-edge clock.
REQ-003 SHALL have ports: rst input 1, reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid input 1, request strobe; req_ready output 1, unit idle and accepting.
REQ-005 SHALL have ports: is_store input 1; funct3 input 3, RV32I width/sign code; addr input 32, byte address; store_data input 32.
REQ-006 SHALL have ports: resp_valid output 1; load_data output 32; err output 1, access rejected.
REQ-007 SHALL have ports: mem_address output 32, word index; mem_wd output 32; mem_memwrite output 1; mem_memread output 1; mem_rd input 32, combinational read data.

Function
REQ-008 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, latching is_store, funct3, addr and store_data; req_ready SHALL be 1 only in IDLE.
REQ-009 SHALL implement states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-010 IDLE transitions on accept: rejected request to RESP; load to LOAD; SW to WRITE; SB/SH to RMW_RD.
REQ-011 mem_address SHALL equal {2'b00, latched addr[31:2]} in LOAD, RMW_RD and WRITE, and 0 otherwise.
REQ-012 LOAD: mem_memread=1 for one cycle; mem_rd is captured at the end of that cycle; then RESP.
REQ-013 Load extraction: byte = mem_rd[8*addr[1:0]+:8] and half = mem_rd[16*addr[1]+:16]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-014 RMW_RD: mem_memread=1 for one cycle; the merged word (read word with the addressed byte/half replaced by store_data[7:0]/[15:0]) is captured; then WRITE.
REQ-015 WRITE: mem_memwrite=1 for exactly one cycle, with mem_wd = store_data (SW) or the merged word (SB/SH); then RESP.
REQ-016 RESP: resp_valid=1 for exactly one cycle; load_data valid for loads and 0 for stores and rejected requests; then IDLE.
REQ-017 Latency from accept edge to resp_valid: load 2 cycles, SW 2, SB/SH 3, rejected 1.
REQ-018 mem_memread and mem_memwrite SHALL never be 1 in the same cycle, and SHALL be 0 in IDLE and RESP.
REQ-019 SHALL reject (err=1 in RESP, no memory strobe) when: illegal funct3 (load 3/6/7; store >2); word index >= MEM_WORDS; or misalignment per REQ-025.
REQ-020 A req_valid asserted while not in IDLE SHALL be ignored, not queued.
REQ-021 Back-to-back operation SHALL work: a request presented in the IDLE cycle following RESP is accepted.

Reset
REQ-022 With rst=0 at a rising edge, the unit SHALL enter IDLE from any state, abandoning any in-flight operation without issuing further mem_memwrite.
REQ-023 Reset values: req_ready=1, resp_valid=0, load_data=0, err=0, mem_memread=0, mem_memwrite=0, mem_address=0, mem_wd=0; latched request and capture registers 0.
REQ-024 Reset held during WRITE SHALL force mem_memwrite=0 in the following cycle.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN: when defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL be rejected per REQ-019; when undefined, the low address bits that violate alignment SHALL be treated as zero (access proceeds aligned) and misalignment never sets err.

Verification
REQ-026 SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> mem_address=4 with a one-cycle memwrite; then load_data=0xDEADBEEF, resp_valid 2 cycles after accept.
REQ-027 Word 4 holds 0xDEADBEEF; SB addr=0x11 data=0x55 -> RMW read, then write mem_wd=0xDEAD55EF; latency 3.
REQ-028 Word 4 holds 0xDEAD55EF; LB addr=0x13 -> load_data=0xFFFFFFDE; LBU -> 0x000000DE; LHU addr=0x12 -> 0x0000DEAD.
REQ-029 LW addr=0x12 with LSU_MISALIGN_TRAP_EN -> err=1, no memory strobe, resp after 1 cycle; without the macro -> reads word 4, err=0.
REQ-030 LW addr=0x100 (index 64, MEM_WORDS=64) -> err=1, no strobe; funct3=3 load -> err=1.
REQ-031 rst=0 asserted during SB's RMW_RD -> IDLE next cycle, memwrite never asserted, word 4 unchanged, req_ready=1.
